// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-bank write-port arbiter.
// Pulled in by reg_write_arbiter and arb_starve_counter.
package reg_write_arbiter_pkg;

  localparam int REG_ID_W = 5;
  localparam logic [REG_ID_W-1:0] REG_ZERO_ID = 5'd0;
  localparam int WAIT_W = 4;
  localparam int CONFLICT_W = 16;

  typedef enum logic {
    ARB_S_RUN   = 1'b0,
    ARB_S_STALL = 1'b1
  } arb_state_t;

  // $zero is hardwired in the register bank, so writes to it must never be enabled.
  function automatic logic writes_reg(input logic [REG_ID_W-1:0] id);
    return id != REG_ZERO_ID;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles the MDU is denied the write port and flags the
// denial that must turn into a one-cycle pipeline stall.
module arb_starve_counter
  import reg_write_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic deny,
  output logic stall_hit
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("arb_starve_counter: MAX_WAIT must be in 1..15");
  end

  assign stall_hit = deny && (wait_cnt == LIMIT);

  // Any cycle without a denial breaks the streak; hitting the limit restarts it too.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (deny && !stall_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register bank write port between writeback (fixed priority)
// and the MDU (valid/ready). Optional stats counter under REG_ARB_STATS_EN.
//
//   state        | meaning
//   ARB_S_RUN    | normal operation, writeback wins, MDU takes idle slots
//   ARB_S_STALL  | pipeline frozen for one cycle so a starved MDU result retires
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wb_write_en,
  input  logic [REG_ID_W-1:0]   wb_write_id,
  input  logic [DATA_W-1:0]     wb_write_value,
  input  logic                  mdu_req_valid,
  input  logic [REG_ID_W-1:0]   mdu_req_id,
  input  logic [DATA_W-1:0]     mdu_req_value,
  output logic                  mdu_req_ready,
  output logic                  pipe_stall,
  output logic                  reg_write_en,
  output logic [REG_ID_W-1:0]   reg_write_id,
  output logic [DATA_W-1:0]     reg_write_value,
  output logic [CONFLICT_W-1:0] conflict_count
);

  arb_state_t state, state_nxt;

  logic                in_stall;
  logic                deny;
  logic                stall_hit;
  logic                sel_en;
  logic [REG_ID_W-1:0] sel_id;
  logic [DATA_W-1:0]   sel_value;

  assign in_stall   = (state == ARB_S_STALL);
  assign pipe_stall = in_stall;

  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clock     (clock),
    .reset_n   (reset_n),
    .deny      (deny),
    .stall_hit (stall_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ARB_S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Writeback is ignored while stalled; the frozen pipeline replays it afterwards.
  always_comb begin
    mdu_req_ready = 1'b0;
    deny          = 1'b0;
    sel_en        = 1'b0;
    sel_id        = wb_write_id;
    sel_value     = wb_write_value;
    state_nxt     = ARB_S_RUN;

    if (in_stall) begin
      mdu_req_ready = mdu_req_valid;
    end else begin
      mdu_req_ready = mdu_req_valid && !wb_write_en;
      deny          = mdu_req_valid && wb_write_en;
      if (stall_hit) begin
        state_nxt = ARB_S_STALL;
      end
    end

    if (!in_stall && wb_write_en) begin
      sel_en = 1'b1;
    end else if (mdu_req_ready) begin
      sel_en    = 1'b1;
      sel_id    = mdu_req_id;
      sel_value = mdu_req_value;
    end
  end

  // A $zero write is treated as if nothing was granted: enable low, id/value hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      reg_write_en    <= 1'b0;
      reg_write_id    <= '0;
      reg_write_value <= '0;
    end else begin
      reg_write_en <= sel_en && writes_reg(sel_id);
      if (sel_en && writes_reg(sel_id)) begin
        reg_write_id    <= sel_id;
        reg_write_value <= sel_value;
      end
    end
  end

`ifdef REG_ARB_STATS_EN
  logic [CONFLICT_W-1:0] conflict_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      conflict_q <= '0;
    end else if (deny && (conflict_q != {CONFLICT_W{1'b1}})) begin
      conflict_q <= conflict_q + 1'b1;
    end
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: three instances (MAX_WAIT 4, 15, 1)
// share stimulus and are checked against a cycle-level reference model.
module tb_reg_write_arbiter;

  localparam int N = 3;
  localparam int MAXW [N] = '{4, 15, 1};
`ifdef REG_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_write_en = 1'b0;
  logic [4:0]  wb_write_id = '0;
  logic [31:0] wb_write_value = '0;
  logic        mdu_req_valid = 1'b0;
  logic [4:0]  mdu_req_id = '0;
  logic [31:0] mdu_req_value = '0;

  logic [N-1:0]        rdy, stl, en;
  logic [N-1:0][4:0]   id;
  logic [N-1:0][31:0]  val;
  logic [N-1:0][15:0]  conf;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  reg_write_arbiter #(.DATA_W(32), .MAX_WAIT(4)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .wb_write_en(wb_write_en), .wb_write_id(wb_write_id), .wb_write_value(wb_write_value),
    .mdu_req_valid(mdu_req_valid), .mdu_req_id(mdu_req_id), .mdu_req_value(mdu_req_value),
    .mdu_req_ready(rdy[0]), .pipe_stall(stl[0]), .reg_write_en(en[0]),
    .reg_write_id(id[0]), .reg_write_value(val[0]), .conflict_count(conf[0]));

  reg_write_arbiter #(.DATA_W(32), .MAX_WAIT(15)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .wb_write_en(wb_write_en), .wb_write_id(wb_write_id), .wb_write_value(wb_write_value),
    .mdu_req_valid(mdu_req_valid), .mdu_req_id(mdu_req_id), .mdu_req_value(mdu_req_value),
    .mdu_req_ready(rdy[1]), .pipe_stall(stl[1]), .reg_write_en(en[1]),
    .reg_write_id(id[1]), .reg_write_value(val[1]), .conflict_count(conf[1]));

  reg_write_arbiter #(.DATA_W(32), .MAX_WAIT(1)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .wb_write_en(wb_write_en), .wb_write_id(wb_write_id), .wb_write_value(wb_write_value),
    .mdu_req_valid(mdu_req_valid), .mdu_req_id(mdu_req_id), .mdu_req_value(mdu_req_value),
    .mdu_req_ready(rdy[2]), .pipe_stall(stl[2]), .reg_write_en(en[2]),
    .reg_write_id(id[2]), .reg_write_value(val[2]), .conflict_count(conf[2]));

  // Reference model: "streak" counts denials in a row; reaching MAX_WAIT schedules a stall.
  bit          m_stall  [N];
  int          m_streak [N];
  bit          m_en     [N];
  logic [4:0]  m_id     [N];
  logic [31:0] m_val    [N];
  int          m_conf   [N];

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        m_stall[i] = 0; m_streak[i] = 0; m_en[i] = 0;
        m_id[i] = '0; m_val[i] = '0; m_conf[i] = 0;
      end else begin
        bit wb_wins, mdu_wins, denied;
        logic [4:0] wid;
        logic [31:0] wv;
        wb_wins  = !m_stall[i] && wb_write_en;
        mdu_wins = !wb_wins && mdu_req_valid;
        denied   = !m_stall[i] && wb_write_en && mdu_req_valid;
        wid = wb_wins ? wb_write_id : mdu_req_id;
        wv  = wb_wins ? wb_write_value : mdu_req_value;
        m_en[i] = (wb_wins || mdu_wins) && (wid != 0);
        if (m_en[i]) begin m_id[i] = wid; m_val[i] = wv; end
        m_stall[i] = 0;
        if (denied) begin
          m_streak[i]++;
          if (m_streak[i] == MAXW[i]) begin m_stall[i] = 1; m_streak[i] = 0; end
          if (m_conf[i] < 65535) m_conf[i]++;
        end else begin
          m_streak[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic we, input logic [4:0] wid, input logic [31:0] wv,
                       input logic mv, input logic [4:0] mid, input logic [31:0] mval);
    wb_write_en = we; wb_write_id = wid; wb_write_value = wv;
    mdu_req_valid = mv; mdu_req_id = mid; mdu_req_value = mval;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive(1, 5'd7, 32'h7777, 1, 5'd9, 32'h9999);
    tick();
    tick();
    n_asserts++;
    if ({en[0], stl[0], rdy[0]} !== 3'b000 || id[0] !== 5'd0 || val[0] !== 32'd0 || conf[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b stall=%b ready=%b id=%0d val=%h conf=%0d, required all 0",
               en[0], stl[0], rdy[0], id[0], val[0], conf[0]);
    end
    reset_n = 1'b1;
    drive(1, 5'd5, 32'h1234, 0, 0, 0);
    tick();
    n_asserts++;
    if (en[0] !== 1'b1 || id[0] !== 5'd5 || val[0] !== 32'h1234) begin
      n_fail++;
      $display("FAIL reset_first_write: en=%b id=%0d val=%h, required 1/5/00001234", en[0], id[0], val[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mdu_only();
    drive(0, 0, 0, 1, 5'd9, 32'hDEADBEEF);
    n_asserts++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mdu_only_ready: got %b, required 1", rdy[0]);
    end
    tick();
    n_asserts++;
    if (en[0] !== 1'b1 || id[0] !== 5'd9 || val[0] !== 32'hDEADBEEF || stl[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mdu_only_write: en=%b id=%0d val=%h stall=%b, required 1/9/deadbeef/0",
               en[0], id[0], val[0], stl[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_asserts++;
    if (en[0] !== 1'b0 || id[0] !== 5'd9 || val[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL idle_hold: en=%b id=%0d val=%h, required 0/9/deadbeef", en[0], id[0], val[0]);
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(k + 1), 32'(k + 100), 1, 5'd12, 32'hCAFE);
      n_asserts++;
      if (rdy[0] !== 1'b0 || stl[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_deny_c%0d: ready=%b stall=%b, required 0/0", k, rdy[0], stl[0]);
      end
      tick();
      n_asserts++;
      if (en[0] !== 1'b1 || id[0] !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL contention_wb_c%0d: en=%b id=%0d, required 1/%0d", k, en[0], id[0], k + 1);
      end
    end
    drive(1, 5'd20, 32'h2020, 1, 5'd12, 32'hCAFE);
    n_asserts++;
    if (stl[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_stall_c4: stall=%b ready=%b, required 1/1", stl[0], rdy[0]);
    end
    tick();
    drive(1, 5'd20, 32'h2020, 0, 0, 0);
    n_asserts++;
    if (en[0] !== 1'b1 || id[0] !== 5'd12 || val[0] !== 32'hCAFE || stl[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_mdu_c5: en=%b id=%0d val=%h stall=%b, required 1/12/0000cafe/0",
               en[0], id[0], val[0], stl[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_zero();
    drive(1, 5'd0, 32'h5555, 0, 0, 0);
    tick();
    n_asserts++;
    if (en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_wb: en=%b, required 0", en[0]);
    end
    drive(0, 0, 0, 1, 5'd0, 32'h6666);
    n_asserts++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mdu_ready: got %b, required 1", rdy[0]);
    end
    tick();
    n_asserts++;
    if (en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_mdu: en=%b, required 0", en[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_stall_interaction();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd2, 32'h2222, 1, 5'd14, 32'hABCD);
      tick();
    end
    drive(1, 5'd3, 32'h3333, 1, 5'd14, 32'hABCD);
    n_asserts++;
    if (stl[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ignore_wb_ready: stall=%b ready=%b, required 1/1", stl[0], rdy[0]);
    end
    tick();
    n_asserts++;
    if (en[0] !== 1'b1 || id[0] !== 5'd14 || val[0] !== 32'hABCD) begin
      n_fail++;
      $display("FAIL stall_ignore_wb: en=%b id=%0d val=%h, required 1/14/0000abcd", en[0], id[0], val[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_max_wait_one();
    do_reset();
    drive(1, 5'd4, 32'h44, 1, 5'd8, 32'h88);
    tick();
    n_asserts++;
    if (stl[2] !== 1'b1 || rdy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL max_wait1_stall: stall=%b ready=%b, required 1/1", stl[2], rdy[2]);
    end
    tick();
    n_asserts++;
    if (en[2] !== 1'b1 || id[2] !== 5'd8 || stl[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL max_wait1_write: en=%b id=%0d stall=%b, required 1/8/0", en[2], id[2], stl[2]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1, 5'd6, 32'h66, 1, 5'd10, 32'hAA);
      tick();
      n_asserts++;
      if (stl[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL stats_no_stall_c%0d: stall=%b, required 0", k, stl[1]);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_asserts++;
    if (conf[1] !== (STATS ? 16'd7 : 16'd0)) begin
      n_fail++;
      $display("FAIL stats_count: got %0d, required %0d", conf[1], STATS ? 7 : 0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [4:0] wid, mid;
      wid = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mid = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      reset_n = ($urandom_range(0, 63) != 0);
      drive(logic'($urandom_range(0, 9) < 6), wid, $urandom,
            logic'($urandom_range(0, 9) < 6), mid, $urandom);
      for (int i = 0; i < N; i++) begin
        logic exp_rdy;
        exp_rdy = mdu_req_valid && (m_stall[i] || !wb_write_en);
        n_asserts++;
        if (rdy[i] !== exp_rdy || stl[i] !== logic'(m_stall[i]) || en[i] !== logic'(m_en[i]) ||
            conf[i] !== (STATS ? 16'(m_conf[i]) : 16'd0) ||
            (m_en[i] && (id[i] !== m_id[i] || val[i] !== m_val[i]))) begin
          n_fail++;
          $display("FAIL random_c%0d_dut%0d: ready=%b stall=%b en=%b id=%0d val=%h conf=%0d, required %b/%b/%b/%0d/%h/%0d",
                   c, i, rdy[i], stl[i], en[i], id[i], val[i], conf[i],
                   exp_rdy, m_stall[i], m_en[i], m_id[i], m_val[i], STATS ? m_conf[i] : 0);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mdu_only();
    test_contention();
    test_zero();
    test_stall_interaction();
    test_max_wait_one();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
